// File: rtl/logic_arbiter.sv
// logic_arbiter: round-robin share of a single 32-bit logic unit among NREQ requesters.
// Ports: clk/rst (sync, active-high); req_valid/req_a/req_b/req_sel in, req_ready out
//        (flattened per requester); rsp_valid/rsp_data/rsp_id/rsp_sel out with rsp_ready in;
//        issue_cnt counts accepted operations modulo 2^CNTW.

module logic_u (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  sel,
   output logic [31:0] y
);
   always_comb begin
      y = '0;
      unique case (sel)
         3'b000:  y = a & b;
         3'b100:  y = a | b;
         3'b010:  y = ~a & ~b;
         3'b110:  y = ~a | ~b;
         3'b001:  y = a ^ b;
         3'b101:  y = ~(a ^ b);
         3'b011:  y = ~a;
         3'b111:  y = ~a + 32'd1;
         default: y = '0;
      endcase
   end
endmodule

module logic_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   input  logic [3*NREQ-1:0]    req_sel,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_data,
   output logic [IDW-1:0]       rsp_id,
   output logic [2:0]           rsp_sel,
   output logic [CNTW-1:0]      issue_cnt
);
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  gid;
   logic [IDW-1:0]  nxt_ptr;
   logic [NREQ-1:0] upper;
   logic [NREQ-1:0] gnt_oh;
   logic            any_vld;
   logic            any_up;
   logic            can_issue;
   logic            accept;
   logic [31:0]     a_m;
   logic [31:0]     b_m;
   logic [2:0]      sel_m;
   logic [31:0]     y;

   assign can_issue = !rsp_valid || rsp_ready;
   assign any_vld   = |req_valid;
   // nothing is offered while reset is held, so no request is lost to it
   assign accept    = can_issue && any_vld && !rst;

   // requesters at or above ptr take precedence; if none, wrap to the bottom
   always_comb begin
      upper = '0;
      for (int i = 0; i < NREQ; i++) begin
         upper[i] = req_valid[i] && (IDW'(i) >= ptr);
      end
   end

   assign any_up = |upper;

   // descending scan so the lowest qualifying index is the last write
   always_comb begin
      gid = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (any_up ? upper[i] : req_valid[i]) begin
            gid = IDW'(i);
         end
      end
   end

   always_comb begin
      gnt_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         gnt_oh[i] = any_vld && (IDW'(i) == gid);
      end
   end

   assign req_ready = gnt_oh & {NREQ{can_issue && !rst}};

   // one-hot AND-OR operand mux
   always_comb begin
      a_m   = '0;
      b_m   = '0;
      sel_m = '0;
      for (int i = 0; i < NREQ; i++) begin
         a_m   = a_m   | (req_a[32*i +: 32] & {32{gnt_oh[i]}});
         b_m   = b_m   | (req_b[32*i +: 32] & {32{gnt_oh[i]}});
         sel_m = sel_m | (req_sel[3*i +: 3] & {3{gnt_oh[i]}});
      end
   end

   logic_u u_logic (
      .a   (a_m),
      .b   (b_m),
      .sel (sel_m),
      .y   (y)
   );

   assign nxt_ptr = (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         rsp_sel   <= '0;
         issue_cnt <= '0;
      end else if (accept) begin
         ptr       <= nxt_ptr;
         rsp_valid <= 1'b1;
         rsp_data  <= y;
         rsp_id    <= gid;
         rsp_sel   <= sel_m;
         issue_cnt <= issue_cnt + CNTW'(1);
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end
endmodule
